// File: rtl/ipm2l_fifo_burst_rd_sched_if.sv
// ---------------------------------------------------------------------------
// ipm2l_fifo_burst_rd_sched_if
//   Bundles the FIFO read-side signals and the outgoing valid/ready stream of
//   the burst read scheduler.
//
//   master : the scheduler (drives fifo_r_en, m_valid, m_data, m_last, busy)
//   slave  : the environment (FIFO controller/RAM, stream sink, control)
//
//   enable              control -> sched  allow new bursts to start
//   fifo_r_en           sched -> FIFO     read enable
//   fifo_rempty         FIFO -> sched     empty flag, valid for current cycle
//   fifo_rd_water_level FIFO -> sched     read-side occupancy
//   fifo_rdata          RAM -> sched      read data, 1 cycle after fifo_r_en
//   m_valid/m_ready     stream handshake
//   m_data/m_last       stream payload and end-of-burst marker
//   busy                scheduler FSM not idle
// ---------------------------------------------------------------------------
interface ipm2l_fifo_burst_rd_sched_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int LEVEL_WIDTH = 10
);
    logic                   enable;
    logic                   fifo_r_en;
    logic                   fifo_rempty;
    logic [LEVEL_WIDTH-1:0] fifo_rd_water_level;
    logic [DATA_WIDTH-1:0]  fifo_rdata;
    logic                   m_valid;
    logic                   m_ready;
    logic [DATA_WIDTH-1:0]  m_data;
    logic                   m_last;
    logic                   busy;

    modport master (
        input  enable,
        input  fifo_rempty,
        input  fifo_rd_water_level,
        input  fifo_rdata,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data,
        output m_last,
        output busy
    );

    modport slave (
        output enable,
        output fifo_rempty,
        output fifo_rd_water_level,
        output fifo_rdata,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data,
        input  m_last,
        input  busy
    );
endinterface

// File: rtl/ipm2l_fifo_burst_rd_sched.sv
// ---------------------------------------------------------------------------
// ipm2l_fifo_burst_rd_sched
//   Drains a synchronous FIFO in fixed bursts of BURST_LEN words. Words that
//   linger below burst size for FLUSH_TIMEOUT idle cycles are sent as a
//   shorter flush burst. The 1-cycle-latency RAM read is turned into a
//   valid/ready stream through a 2-entry skid buffer, with m_last tagging the
//   final word of each burst.
//
//   clk   : single clock for FIFO read side and stream
//   rst_n : asynchronous reset, active low
//   bus   : ipm2l_fifo_burst_rd_sched_if.master (FIFO read side, stream,
//           enable and busy)
// ---------------------------------------------------------------------------
module ipm2l_fifo_burst_rd_sched #(
    parameter int DATA_WIDTH    = 32,
    parameter int LEVEL_WIDTH   = 10,
    parameter int BURST_LEN     = 16,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    ipm2l_fifo_burst_rd_sched_if.master   bus
);
    localparam int ICW = $clog2(BURST_LEN + 1);
    localparam int TW  = $clog2(FLUSH_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ICW-1:0]        issue_cnt_q, issue_cnt_d;
    logic [TW-1:0]         idle_tmr_q, idle_tmr_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [1:0]            buf_cnt_q, buf_cnt_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [1:0]            buf_last_q, buf_last_d;

    logic [LEVEL_WIDTH-1:0] level;
    logic                   lvl_full;
    logic                   lvl_nz;
    logic                   tmr_expired;
    logic                   start_full;
    logic                   start_flush;
    logic                   m_valid;
    logic                   pop;
    logic [2:0]             occ_after;
    logic                   credit_ok;
    logic                   r_en;
    logic                   wr_idx;

    assign level       = bus.fifo_rd_water_level;
    assign lvl_full    = level >= LEVEL_WIDTH'(BURST_LEN);
    assign lvl_nz      = level != '0;
    assign tmr_expired = idle_tmr_q == TW'(FLUSH_TIMEOUT);
    assign start_full  = (state_q == S_IDLE) && bus.enable && lvl_full;
    assign start_flush = (state_q == S_IDLE) && bus.enable && lvl_nz && tmr_expired;

    assign m_valid = buf_cnt_q != 2'd0;
    assign pop     = m_valid && bus.m_ready;

    // Occupancy once this cycle's landing word and pop are accounted for.
    // A word leaving the buffer returns its credit in the same cycle, which
    // keeps the read pipeline at one word per cycle when the sink is ready;
    // a completely full buffer never issues, so buf_cnt + inflight stays <= 2.
    assign occ_after = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign credit_ok = (buf_cnt_q != 2'd2) && (occ_after < 3'd2);

    assign r_en = (state_q == S_BURST) && (issue_cnt_q != '0)
                  && !bus.fifo_rempty && credit_ok;

    // ------------------------------------------------------------------
    // Burst FSM and idle timer
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        idle_tmr_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start_full) begin
                    state_d     = S_BURST;
                    issue_cnt_d = ICW'(BURST_LEN);
                end else if (start_flush) begin
                    // Full-burst case already failed, so level < BURST_LEN
                    // and fits the issue counter.
                    state_d     = S_BURST;
                    issue_cnt_d = ICW'(level);
                end else if (bus.enable && lvl_nz && !lvl_full) begin
                    idle_tmr_d = tmr_expired ? idle_tmr_q : idle_tmr_q + 1'b1;
                end
            end
            S_BURST: begin
                if (issue_cnt_q == '0) begin
                    state_d = S_DRAIN;
                end else if (r_en) begin
                    issue_cnt_d = issue_cnt_q - 1'b1;
                    if (issue_cnt_q == ICW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if ((buf_cnt_q == 2'd0) && !inflight_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Skid buffer: entry 0 is the head; a pop shifts entry 1 down and the
    // landing word goes to the first free slot after that shift.
    // ------------------------------------------------------------------
    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        if (pop) begin
            buf_data_d[0] = buf_data_q[1];
            buf_last_d[0] = buf_last_q[1];
        end
        wr_idx = (buf_cnt_q == 2'd2) || ((buf_cnt_q == 2'd1) && !pop);
        if (inflight_q) begin
            buf_data_d[wr_idx] = bus.fifo_rdata;
            buf_last_d[wr_idx] = inflight_last_q;
        end
        buf_cnt_d = 2'(buf_cnt_q + 2'(inflight_q) - 2'(pop));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            issue_cnt_q     <= '0;
            idle_tmr_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_cnt_q       <= 2'd0;
            buf_last_q      <= 2'b00;
        end else begin
            state_q         <= state_d;
            issue_cnt_q     <= issue_cnt_d;
            idle_tmr_q      <= idle_tmr_d;
            inflight_q      <= r_en;
            inflight_last_q <= r_en && (issue_cnt_q == ICW'(1));
            buf_cnt_q       <= buf_cnt_d;
            buf_last_q      <= buf_last_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                buf_data_q[gi] <= '0;
            end else begin
                buf_data_q[gi] <= buf_data_d[gi];
            end
        end
    end

    assign bus.fifo_r_en = r_en;
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = buf_data_q[0];
    assign bus.m_last    = buf_last_q[0] && m_valid;
    assign bus.busy      = state_q != S_IDLE;

endmodule
